// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run-control sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } run_state_e;

    localparam int DEF_NUM_CORES  = 1;
    localparam int DEF_RST_HOLD   = 2;
    localparam int DEF_CYCLE_W    = 16;
    localparam int DEF_MAX_CYCLES = 200;

    localparam int HOLD_CNT_W = $clog2(DEF_RST_HOLD + 1);

    function automatic int hold_cnt_width(input int rst_hold);
        return $clog2(rst_hold + 1);
    endfunction

endpackage

// File: rtl/run_controller_if.sv
// Run-control bundle between the sequencer (master) and the harness/cores (slave).
interface run_controller_if #(
    parameter int NUM_CORES = 1,
    parameter int CYCLE_W   = 16
);
    logic                           start;
    logic [NUM_CORES-1:0]           core_rst;
    logic [NUM_CORES-1:0]           core_halt;
    logic                           running;
    logic                           done;
    logic                           timeout;
    logic [NUM_CORES-1:0]           halted_mask;
    logic [CYCLE_W-1:0]             cycle_count;
    logic [NUM_CORES*CYCLE_W-1:0]   halt_cycle;

    modport master (
        input  start, core_halt,
        output core_rst, running, done, timeout, halted_mask, cycle_count, halt_cycle
    );

    modport slave (
        output start, core_halt,
        input  core_rst, running, done, timeout, halted_mask, cycle_count, halt_cycle
    );
endinterface

// File: rtl/run_halt_tracker.sv
// Per-core sticky halt flag; with RUN_CTRL_HALT_TRACE_EN also a first-halt timestamp.
`ifdef RUN_CTRL_HALT_TRACE_EN
module run_halt_tracker #(
    parameter int CYCLE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               halt_in,
    input  logic [CYCLE_W-1:0] cycle_next,
    output logic [CYCLE_W-1:0] stamp,
    output logic               halted
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
            stamp  <= '0;
        end else if (clr) begin
            halted <= 1'b0;
            stamp  <= '0;
        end else if (en && halt_in && !halted) begin
            halted <= 1'b1;
            stamp  <= cycle_next;
        end
    end
endmodule
`else
module run_halt_tracker (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic halt_in,
    output logic halted
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (clr) begin
            halted <= 1'b0;
        end else if (en && halt_in) begin
            halted <= 1'b1;
        end
    end
endmodule
`endif

// File: rtl/run_controller.sv
// Run-control sequencer: core reset pulse, budgeted run, halt/timeout reporting.
// Optional halt timestamps are enabled with RUN_CTRL_HALT_TRACE_EN.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int RST_HOLD   = DEF_RST_HOLD,
    parameter int CYCLE_W    = DEF_CYCLE_W,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    run_controller_if.master  bus
);
    localparam int HOLD_W = hold_cnt_width(RST_HOLD);
    localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(RST_HOLD - 1);
    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLES - 1);

    run_state_e state, state_next;

    logic [HOLD_W-1:0]    hold_cnt;
    logic [CYCLE_W-1:0]   cycle_count;
    logic [CYCLE_W-1:0]   cycle_next;
    logic [NUM_CORES-1:0] halted_q;
    logic                 run_clr;
    logic                 timeout_set;
    logic                 all_halted;
    logic                 in_run;
    logic                 running_q;
    logic                 done_q;
    logic                 timeout_q;
    logic [NUM_CORES-1:0] core_rst_q;

    assign in_run     = (state == RUN);
    assign cycle_next = cycle_count + CYCLE_W'(1);
    // A halt arriving in the same cycle as the last outstanding core counts immediately.
    assign all_halted = &(halted_q | bus.core_halt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        run_clr     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RESET;
                    run_clr    = 1'b1;
                end
            end
            RESET: begin
                if (hold_cnt == LAST_HOLD) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (all_halted) begin
                    state_next = DONE;
                end else if (cycle_count == LAST_CYCLE) begin
                    state_next  = DONE;
                    timeout_set = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = RESET;
                    run_clr    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state != RESET) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
            timeout_q   <= 1'b0;
        end else if (run_clr) begin
            cycle_count <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (in_run) begin
                cycle_count <= cycle_next;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= '1;
        end else begin
            running_q  <= (state_next == RUN);
            done_q     <= (state_next == DONE);
            core_rst_q <= {NUM_CORES{(state_next != RUN) && (state_next != DONE)}};
        end
    end

`ifdef RUN_CTRL_HALT_TRACE_EN
    logic [NUM_CORES*CYCLE_W-1:0] halt_flat;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_trk
        run_halt_tracker #(
            .CYCLE_W (CYCLE_W)
        ) u_trk (
            .clk        (clk),
            .rst        (rst),
            .clr        (run_clr),
            .en         (in_run),
            .halt_in    (bus.core_halt[i]),
            .cycle_next (cycle_next),
            .stamp      (halt_flat[i*CYCLE_W +: CYCLE_W]),
            .halted     (halted_q[i])
        );
    end

    assign bus.halt_cycle = halt_flat;
`else
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_trk
        run_halt_tracker u_trk (
            .clk     (clk),
            .rst     (rst),
            .clr     (run_clr),
            .en      (in_run),
            .halt_in (bus.core_halt[i]),
            .halted  (halted_q[i])
        );
    end

    assign bus.halt_cycle = '0;
`endif

    assign bus.core_rst    = core_rst_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.halted_mask = halted_q;
    assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: one single-core 200-cycle instance, one dual-core 50-cycle instance.
module tb_run_controller;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    run_controller_if #(.NUM_CORES(1), .CYCLE_W(16)) ia ();
    run_controller_if #(.NUM_CORES(2), .CYCLE_W(16)) ib ();

    run_controller #(
        .NUM_CORES  (1),
        .RST_HOLD   (2),
        .CYCLE_W    (16),
        .MAX_CYCLES (200)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.master)
    );

    run_controller #(
        .NUM_CORES  (2),
        .RST_HOLD   (2),
        .CYCLE_W    (16),
        .MAX_CYCLES (50)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_b();
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
    endtask

    task automatic advance_b(input int target);
        int n = 0;
        while (ib.cycle_count != 16'(target) && n < 100) begin
            tick();
            n++;
        end
        check("reach_count", 64'(ib.cycle_count), 64'(target));
    endtask

    task automatic halt_b(input logic [1:0] mask);
        ib.core_halt = mask;
        tick();
        ib.core_halt = 2'b00;
    endtask

    initial begin
        int n_run;
        int n_wait;
        logic [31:0] exp_hc;

        rst_a = 1'b0;
        rst_b = 1'b0;
        ia.start = 1'b0;
        ia.core_halt = 1'b0;
        ib.start = 1'b0;
        ib.core_halt = 2'b00;
        tick();
        tick();

        // reset values
        check("a_rst_core_rst", 64'(ia.core_rst), 64'h1);
        check("a_rst_running",  64'(ia.running), 64'h0);
        check("a_rst_done",     64'(ia.done), 64'h0);
        check("a_rst_timeout",  64'(ia.timeout), 64'h0);
        check("a_rst_mask",     64'(ia.halted_mask), 64'h0);
        check("a_rst_count",    64'(ia.cycle_count), 64'h0);
        check("a_rst_hc",       64'(ia.halt_cycle), 64'h0);
        check("b_rst_core_rst", 64'(ib.core_rst), 64'h3);

        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // single core, no halts: full-budget timeout
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        check("a_hold1_core_rst", 64'(ia.core_rst), 64'h1);
        check("a_hold1_running",  64'(ia.running), 64'h0);
        tick();
        check("a_hold2_core_rst", 64'(ia.core_rst), 64'h1);
        tick();
        check("a_run_core_rst", 64'(ia.core_rst), 64'h0);
        check("a_run_running",  64'(ia.running), 64'h1);
        check("a_run_count0",   64'(ia.cycle_count), 64'h0);
        n_run = 0;
        n_wait = 0;
        while (!ia.done && n_wait < 300) begin
            if (ia.running) n_run++;
            tick();
            n_wait++;
        end
        check("a_run_cycles", 64'(n_run), 64'd200);
        check("a_done",       64'(ia.done), 64'h1);
        check("a_timeout",    64'(ia.timeout), 64'h1);
        check("a_count",      64'(ia.cycle_count), 64'd200);
        check("a_done_run",   64'(ia.running), 64'h0);
        check("a_done_crst",  64'(ia.core_rst), 64'h0);

        // halts in IDLE are ignored
        halt_b(2'b11);
        check("b_idle_mask", 64'(ib.halted_mask), 64'h0);
        check("b_idle_done", 64'(ib.done), 64'h0);

        // dual core, halts at RUN cycles 10 and 37
        start_b();
        check("b_hold1_crst", 64'(ib.core_rst), 64'h3);
        tick();
        check("b_hold2_crst", 64'(ib.core_rst), 64'h3);
        tick();
        check("b_run_crst", 64'(ib.core_rst), 64'h0);
        advance_b(9);
        halt_b(2'b01);
        check("b_mask_01",    64'(ib.halted_mask), 64'h1);
        check("b_still_run",  64'(ib.running), 64'h1);
        advance_b(36);
        halt_b(2'b10);
        check("b_t2_done",    64'(ib.done), 64'h1);
        check("b_t2_timeout", 64'(ib.timeout), 64'h0);
        check("b_t2_count",   64'(ib.cycle_count), 64'd37);
        check("b_t2_mask",    64'(ib.halted_mask), 64'h3);
        check("b_t2_running", 64'(ib.running), 64'h0);
`ifdef RUN_CTRL_HALT_TRACE_EN
        exp_hc = {16'd37, 16'd10};
`else
        exp_hc = 32'h0;
`endif
        check("b_t2_hc", 64'(ib.halt_cycle), 64'(exp_hc));

        // restart from DONE clears frozen results; last halt lands in the final budget cycle
        start_b();
        check("b_rs_mask",    64'(ib.halted_mask), 64'h0);
        check("b_rs_count",   64'(ib.cycle_count), 64'h0);
        check("b_rs_timeout", 64'(ib.timeout), 64'h0);
        check("b_rs_done",    64'(ib.done), 64'h0);
        check("b_rs_crst",    64'(ib.core_rst), 64'h3);
        check("b_rs_hc",      64'(ib.halt_cycle), 64'h0);
        tick();
        check("b_rs_crst2",   64'(ib.core_rst), 64'h3);
        tick();
        check("b_rs_crst3",   64'(ib.core_rst), 64'h0);
        advance_b(4);
        halt_b(2'b01);
        advance_b(20);
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        check("b_start_ign_run", 64'(ib.running), 64'h1);
        check("b_start_ign_cnt", 64'(ib.cycle_count), 64'd21);
        advance_b(49);
        halt_b(2'b10);
        check("b_t3_done",    64'(ib.done), 64'h1);
        check("b_t3_timeout", 64'(ib.timeout), 64'h0);
        check("b_t3_count",   64'(ib.cycle_count), 64'd50);
        check("b_t3_mask",    64'(ib.halted_mask), 64'h3);
`ifdef RUN_CTRL_HALT_TRACE_EN
        exp_hc = {16'd50, 16'd5};
`else
        exp_hc = 32'h0;
`endif
        check("b_t3_hc", 64'(ib.halt_cycle), 64'(exp_hc));

        // timeout with only core 0 halted; halts in DONE are ignored
        start_b();
        tick();
        tick();
        advance_b(2);
        halt_b(2'b01);
        n_wait = 0;
        while (!ib.done && n_wait < 100) begin
            tick();
            n_wait++;
        end
        check("b_t4_done",    64'(ib.done), 64'h1);
        check("b_t4_timeout", 64'(ib.timeout), 64'h1);
        check("b_t4_count",   64'(ib.cycle_count), 64'd50);
        check("b_t4_mask",    64'(ib.halted_mask), 64'h1);
        halt_b(2'b10);
        tick();
        check("b_done_mask",  64'(ib.halted_mask), 64'h1);
        check("b_done_count", 64'(ib.cycle_count), 64'd50);
`ifdef RUN_CTRL_HALT_TRACE_EN
        exp_hc = {16'd0, 16'd3};
`else
        exp_hc = 32'h0;
`endif
        check("b_t4_hc", 64'(ib.halt_cycle), 64'(exp_hc));

        // asynchronous reset in RUN cycle 20
        start_b();
        tick();
        tick();
        halt_b(2'b01);
        advance_b(19);
        rst_b = 1'b0;
        #1;
        check("b_arst_crst",    64'(ib.core_rst), 64'h3);
        check("b_arst_running", 64'(ib.running), 64'h0);
        check("b_arst_count",   64'(ib.cycle_count), 64'h0);
        check("b_arst_mask",    64'(ib.halted_mask), 64'h0);
        tick();
        rst_b = 1'b1;
        tick();
        start_b();
        tick();
        tick();
        check("b_post_running", 64'(ib.running), 64'h1);
        n_wait = 0;
        while (!ib.done && n_wait < 100) begin
            tick();
            n_wait++;
        end
        check("b_post_done",    64'(ib.done), 64'h1);
        check("b_post_timeout", 64'(ib.timeout), 64'h1);
        check("b_post_count",   64'(ib.cycle_count), 64'd50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Synthesizable run-control sequencer; successor to the single-core fixed-200-cycle bench harness.
- Drives per-core synchronous reset pulses to NUM_CORES processor instances.
- Counts execution cycles under a parametrised budget and tracks per-core halt indications.
- Reports completion or timeout, so benches and FPGA wrappers share one stop/pass mechanism.

Parameters:
- NUM_CORES, 1, number of controlled cores (1..8).
- RST_HOLD, 2, cycles core reset is held high (>=1).
- CYCLE_W, 16, width of cycle counter.
- MAX_CYCLES, 200, run budget in cycles (1..2^CYCLE_W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  level-sampled request to begin a run.
- core_rst  output  NUM_CORES  active-high reset to each core.
- core_halt  input  NUM_CORES  per-core halt indication, may pulse.
- running  output  1  high while in RUN.
- done  output  1  high in DONE until the next start.
- timeout  output  1  valid with done; 1 = budget exhausted before all cores halted.
- halted_mask  output  NUM_CORES  sticky per-core halt record.
- cycle_count  output  CYCLE_W  RUN cycles elapsed.
- halt_cycle  output  NUM_CORES*CYCLE_W  per-core halt timestamp (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous), all outputs:
  - state=IDLE, core_rst=all 1s (cores held in reset).
  - running=0, done=0, timeout=0, halted_mask=0, cycle_count=0, halt_cycle=0.
- IDLE:
  - core_rst all 1s.
  - start=1 -> RESET; hold counter cleared; halted_mask, cycle_count and halt_cycle cleared.
- RESET:
  - core_rst all 1s for exactly RST_HOLD cycles, then -> RUN.
  - core_rst deasserts (registered) on the first RUN cycle.
- RUN:
  - running=1; cycle_count increments by 1 every cycle.
  - halted_mask[i] sets on any cycle with core_halt[i]=1 and never clears in RUN.
- RUN exit on halt:
  - When (halted_mask | core_halt) is all 1s -> DONE with timeout=0.
- RUN exit on timeout:
  - When cycle_count==MAX_CYCLES-1 and not all halted -> DONE with timeout=1.
  - cycle_count ends at MAX_CYCLES.
- Simultaneous events: last-halt in the budget-expiry cycle -> halt wins, timeout=0.
- DONE:
  - done=1, running=0.
  - core_rst stays deasserted (cores free-run, inspectable).
  - cycle_count, halted_mask and timeout frozen.
  - start=1 -> RESET (restart, clears the frozen values as in IDLE).
- start is ignored in RESET and RUN.
- core_halt is ignored outside RUN.
- Asynchronous reset mid-RESET or mid-RUN: immediate return to IDLE values; cores re-held in reset.
- cycle_count never wraps: it is bounded by MAX_CYCLES < 2^CYCLE_W.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro RUN_CTRL_HALT_TRACE_EN.
- Defined:
  - halt_cycle slice i captures cycle_count+1 on the first cycle core_halt[i] is seen in RUN.
  - The slice holds that value until the next start.
  - A core that never halts reads 0.
- Undefined:
  - halt_cycle tied to 0 and the capture registers are omitted.
  - Port is kept so the interface is stable.

Decomposition:
- Package run_ctrl_pkg:
  - state enum {IDLE, RESET, RUN, DONE}.
  - Default parameter constants.
  - Localparam for hold-counter width, clog2(RST_HOLD+1).
- Sub-module run_halt_tracker, one instance per core:
  - Sticky halt bit.
  - Optional timestamp capture.
  - Shared clear and enable from the FSM.
- Top level holds the FSM, hold counter and cycle counter.

Test Plan:
- NUM_CORES=1, RST_HOLD=2, MAX_CYCLES=200, core_halt tied 0, pulse start -> core_rst high 2 cycles after start accepted, then running 200 cycles; done=1, timeout=1, cycle_count=200.
- NUM_CORES=2, core_halt[0] pulses at RUN cycle 10, core_halt[1] at cycle 37 -> halted_mask=2'b11, done on cycle 37, timeout=0, cycle_count=37; with macro: halt_cycle = {37, 10}.
- MAX_CYCLES=50, last core halts exactly in RUN cycle 50 -> done=1, timeout=0, cycle_count=50.
- rst driven low at RUN cycle 20 -> same-cycle return: core_rst=all 1s, running=0, cycle_count=0; restart after release runs normally.
- start asserted during RUN -> no effect; after done, start -> halted_mask, cycle_count and timeout cleared, RESET re-entered, core_rst re-pulsed RST_HOLD cycles.
- core_halt pulsed in IDLE and in DONE -> halted_mask unchanged (0 before the run, frozen value after).
